// File: rtl/rand_sampler.sv
// Rejection sampler: masks the upstream LFSR state and queues samples below limit_i, one-cycle push-to-output latency.
// Backpressure: ready_i pops the FIFO head; sampling halts in FULL and resumes on a pop.
module rand_sampler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [31:0]                lfsr_state_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           limit_i,
  output logic [WIDTH-1:0]           rand_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                reject_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, FULL} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [15:0]        reject_cnt;
  logic [WIDTH-1:0]   lim_m1, mask, cand;
  logic               run, empty, full, eval, push, reject, pop;
  logic               unused_lfsr;

  assign unused_lfsr = ^lfsr_state_i[31:WIDTH];

  // Smear limit-1 rightward to get the smallest all-ones cover.
  always_comb begin
    lim_m1 = limit_i - WIDTH'(1);
    mask   = lim_m1;
    for (int i = 1; i < WIDTH; i++) begin
      mask = mask | (lim_m1 >> i);
    end
    if (limit_i == '0) begin
      mask = '0;
    end
  end

  assign cand   = lfsr_state_i[WIDTH-1:0] & mask;
  assign run    = enable_i && (limit_i != '0);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign eval   = (state == SAMPLE) && run && !full;
  assign push   = eval && (cand < limit_i);
  assign reject = eval && !(cand < limit_i);
  assign pop    = !empty && ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = SAMPLE;
      SAMPLE: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (push && !pop && (count == CW'(DEPTH - 1))) begin
          state_nxt = FULL;
        end
      end
      FULL:    if (pop) state_nxt = run ? SAMPLE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      reject_cnt <= '0;
    end else if (clear_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      reject_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (reject && (reject_cnt != 16'hFFFF)) begin
        reject_cnt <= reject_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wr_ptr] <= cand;
    end
  end

  assign rand_o       = empty ? '0 : mem[rd_ptr];
  assign valid_o      = !empty;
  assign count_o      = count;
  assign reject_cnt_o = reject_cnt;

endmodule

// File: tb/tb_rand_sampler.sv
// Bench for rand_sampler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rand_sampler;

  localparam int W = 8;
  localparam int D = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] lfsr_state_i;
  logic        enable_i;
  logic        clear_i;
  logic [W-1:0] limit_i;
  logic [W-1:0] rand_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;
  logic [15:0] reject_cnt_o;

  rand_sampler #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lfsr_state_i (lfsr_state_i),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .limit_i      (limit_i),
    .rand_o       (rand_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .reject_cnt_o (reject_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;

  // Reference model: queue of stored samples, reject tally, mode 0=idle 1=sampling 2=full
  logic [7:0] q[$];
  int         m_rej  = 0;
  int         m_mode = 0;

  logic [27:0] dut_vec;
  assign dut_vec = {rand_o, valid_o, count_o, reject_cnt_o};

  function automatic int mask_of(input int lim);
    int m = 0;
    while (m < lim - 1) m = m * 2 + 1;
    return m;
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [7:0] head;
    int n;
    n    = q.size();
    head = (n > 0) ? q[0] : 8'h00;
    return {head, n > 0, 3'(n), 16'(m_rej)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_rej  = 0;
    m_mode = 0;
  endtask

  // Advance the model with the inputs as presented, then clock the DUT.
  task automatic step();
    int  pre;
    int  lim;
    int  cand;
    bit  do_pop;
    bit  run;
    bit  pushed;
    pre    = q.size();
    lim    = int'(limit_i);
    do_pop = (pre > 0) && ready_i;
    run    = enable_i && (lim != 0);
    pushed = 1'b0;
    if (clear_i) begin
      model_reset();
    end else begin
      if (do_pop) void'(q.pop_front());
      case (m_mode)
        0: if (run) m_mode = 1;
        1: begin
          if (!run) begin
            m_mode = 0;
          end else if (pre < D) begin
            cand = int'(lfsr_state_i[7:0]) & mask_of(lim);
            if (cand < lim) begin
              q.push_back(8'(cand));
              pushed = 1'b1;
            end else if (m_rej < 65535) begin
              m_rej++;
            end
          end
        end
        default: if (do_pop) m_mode = run ? 1 : 0;
      endcase
      if (pushed && q.size() == D) m_mode = 2;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #13;
    vectors++;
    if (dut_vec !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec, 28'h0);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    vectors++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_accept();
    do_clear();
    enable_i = 1'b1; limit_i = 8'd6; ready_i = 1'b0;
    lfsr_state_i = 32'hA5C3_7105;
    step();
    step();
    vectors++;
    if (rand_o !== 8'd5 || valid_o !== 1'b1 || reject_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL accept_first: got rand=%0d valid=%0b rej=%0d expected 5 1 0", rand_o, valid_o, reject_cnt_o);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL accept_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reject();
    do_clear();
    enable_i = 1'b1; limit_i = 8'd6; ready_i = 1'b1;
    lfsr_state_i = 32'h1234_56FF;
    step();
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (valid_o !== 1'b0 || reject_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL reject_three: got valid=%0b rej=%0d expected 0 3", valid_o, reject_cnt_o);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reject_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full();
    do_clear();
    enable_i = 1'b1; limit_i = 8'd6; ready_i = 1'b0;
    lfsr_state_i = 32'h0000_0002;
    step();
    for (int i = 0; i < D; i++) begin
      lfsr_state_i = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 5));
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL full_fill%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      lfsr_state_i = (i % 2 == 0) ? 32'h0000_00FF : 32'h0000_0001;
      step();
      vectors++;
      if (count_o !== 3'd4 || reject_cnt_o !== 16'd0) begin
        errors++;
        $display("FAIL full_hold%0d: got count=%0d rej=%0d expected 4 0", i, count_o, reject_cnt_o);
      end
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    vectors++;
    if (count_o !== 3'd3 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL full_pop: got %h expected %h", dut_vec, exp_vec());
    end
    lfsr_state_i = 32'h0000_0003;
    step();
    vectors++;
    if (count_o !== 3'd4 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL full_resume: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5];
    vals = '{8'd3, 8'd4, 8'd5, 8'd1, 8'd2};
    do_clear();
    enable_i = 1'b1; limit_i = 8'd6; ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ready_i = 1'b1;
      lfsr_state_i = {24'h00BEEF, vals[i]};
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (i >= 2) begin
        vectors++;
        if (count_o !== 3'd2 || rand_o !== vals[i-1]) begin
          errors++;
          $display("FAIL b2b_order%0d: got count=%0d rand=%0d expected 2 %0d", i, count_o, rand_o, vals[i-1]);
        end
      end
    end
    ready_i = 1'b0;
  endtask

  task automatic test_limits();
    do_clear();
    enable_i = 1'b1; limit_i = 8'd0; ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lfsr_state_i = $urandom;
      step();
    end
    vectors++;
    if (count_o !== 3'd0 || reject_cnt_o !== 16'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL limit_zero: got count=%0d rej=%0d valid=%0b expected 0 0 0", count_o, reject_cnt_o, valid_o);
    end
    limit_i = 8'd1; ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lfsr_state_i = $urandom;
      step();
      vectors++;
      if (rand_o !== 8'd0 || reject_cnt_o !== 16'd0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL limit_one%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable_i     = ($urandom % 8) != 0;
      limit_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      ready_i      = $urandom % 2;
      clear_i      = ($urandom % 50) == 0;
      lfsr_state_i = $urandom;
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    clear_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    enable_i = 1'b1; limit_i = 8'd6; ready_i = 1'b0;
    lfsr_state_i = 32'h0000_00FF;
    step();
    for (int i = 0; i < 9; i++) step();
    for (int i = 1; i <= 3; i++) begin
      lfsr_state_i = 32'(i);
      step();
    end
    enable_i = 1'b0;
    vectors++;
    if (count_o !== 3'd3 || reject_cnt_o !== 16'd9 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL areset_setup: got %h expected %h", dut_vec, exp_vec());
    end
    #2;
    reset_i = 1'b1;
    #1;
    vectors++;
    if (dut_vec !== 28'h0) begin
      errors++;
      $display("FAIL areset_clear: got %h expected %h", dut_vec, 28'h0);
    end
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
    step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL areset_after: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    lfsr_state_i = 32'h0;
    enable_i     = 1'b0;
    clear_i      = 1'b0;
    limit_i      = 8'd0;
    ready_i      = 1'b0;
    test_reset();
    test_accept();
    test_reject();
    test_full();
    test_back_to_back();
    test_limits();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rand_sampler.md
RAND_SAMPLER -- requirements
Module: rand_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the output sample width in bits (valid range 2..16).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the output FIFO entries (power of two, 2..16).
REQ-003 Port clk_i  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 Port reset_i  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 Port lfsr_state_i  input  32  SHALL carry the current state of the upstream 32-bit LFSR, which is new every cycle.
REQ-006 Port enable_i  input  1  SHALL request that sampling proceed while high.
REQ-007 Port clear_i  input  1  SHALL be a synchronous flush.
REQ-008 Port limit_i  input  WIDTH  SHALL give the exclusive upper bound of the sample range [0, limit_i).
REQ-009 Port rand_o  output  WIDTH  SHALL present the FIFO head sample.
REQ-010 Port valid_o  output  1  SHALL be high when rand_o holds a valid sample.
REQ-011 Port ready_i  input  1  SHALL indicate that the consumer accepts rand_o.
REQ-012 Port count_o  output  $clog2(DEPTH)+1  SHALL give the current FIFO occupancy.
REQ-013 Port reject_cnt_o  output  16  SHALL count rejected candidates.

Function
REQ-014 The mask SHALL be the smallest all-ones value >= limit_i-1, computed combinationally each cycle; for example, limit 6 gives mask 0x07, limit 1 gives 0x00, and limit 0x80 gives 0x7F.
REQ-015 The candidate SHALL be lfsr_state_i[WIDTH-1:0] & mask.
REQ-016 The FSM SHALL have states IDLE, SAMPLE and FULL.
REQ-017 In IDLE, the FSM SHALL go to SAMPLE when enable_i=1 and limit_i!=0.
REQ-018 In SAMPLE, the FSM SHALL go to IDLE when enable_i=0 or limit_i=0.
REQ-019 In SAMPLE, the FSM SHALL go to FULL when a push makes the FIFO full.
REQ-020 In FULL, the FSM SHALL go to SAMPLE when a pop occurs and enable_i=1 and limit_i!=0, and otherwise to IDLE when a pop occurs.
REQ-021 In SAMPLE with the FIFO not full, a candidate < limit_i SHALL be pushed.
REQ-022 In SAMPLE, a candidate >= limit_i SHALL be rejected and SHALL increment reject_cnt_o, saturating at 0xFFFF.
REQ-023 No candidate evaluation or reject counting SHALL occur in IDLE or FULL.
REQ-024 limit_i SHALL be sampled every cycle; a change takes effect on the next candidate and does not alter samples already stored.
REQ-025 A pop SHALL occur when valid_o=1 and ready_i=1 at the clock edge.
REQ-026 valid_o SHALL equal (count_o != 0).
REQ-027 rand_o SHALL be 0 when the FIFO is empty.
REQ-028 A sample pushed at edge N SHALL be visible on rand_o/valid_o after edge N, i.e. with one-cycle latency.
REQ-029 When push and pop coincide with the FIFO neither empty nor full, both SHALL occur and count_o SHALL be unchanged.
REQ-030 When the FIFO is full, no push SHALL occur in that cycle even if a pop occurs; the pop alone SHALL proceed.
REQ-031 When the FIFO is empty, no pop SHALL occur; a push SHALL proceed.
REQ-032 The read and write pointers SHALL wrap modulo DEPTH.
REQ-033 clear_i=1 SHALL override all other activity in that cycle: count_o goes to 0, pointers go to 0, reject_cnt_o goes to 0, and the FSM goes to IDLE.

Reset
REQ-034 While reset_i=1, regardless of clock: the FSM SHALL be IDLE; count_o, pointers and reject_cnt_o SHALL be 0; valid_o=0; rand_o=0.
REQ-035 FIFO storage contents SHALL be unspecified after reset and never observable.
REQ-036 Reset asserted mid-operation SHALL discard all stored samples immediately.

Verification
REQ-037 The bench SHALL cover: limit_i=6, enable_i=1, lfsr_state_i low byte 0x05 -> rand_o=5, valid_o=1 one cycle later, and reject_cnt_o=0.
REQ-038 The bench SHALL cover: limit_i=6, low byte 0xFF (candidate 7) for 3 cycles -> valid_o stays 0 and reject_cnt_o=3.
REQ-039 The bench SHALL cover: ready_i=0, DEPTH=4, all candidates accepted -> count_o=4, FSM in FULL, and the 5th and later candidates are neither pushed nor counted; then one ready_i pulse -> count_o=3 and sampling resumes.
REQ-040 The bench SHALL cover: FIFO holding 2 entries with simultaneous push and pop -> count_o stays 2 and data stays in FIFO order.
REQ-041 The bench SHALL cover: limit_i=0 with enable_i=1 -> the FSM stays IDLE and count_o stays 0; and limit_i=1 -> every sample is 0 with no rejects.
REQ-042 The bench SHALL cover: reset_i asserted asynchronously between edges with count_o=3 and reject_cnt_o=9 -> all outputs read 0 before the next edge.
